// File: rtl/regfile_scoreboard.sv
// Integer register file with NRD combinational read ports, one write port,
// optional write-to-read bypass and a per-register busy scoreboard.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    output logic                stall,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                busy_set_en,
    input  logic [AW-1:0]       busy_set_addr,
    output logic [CW-1:0]       busy_cnt
);

    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    // x0 and indices beyond the implemented registers never hold state
    function automatic logic idx_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS_W);
    endfunction

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             wr_ok;
    logic             set_ok;
    logic             cnt_inc;
    logic             cnt_dec;

    assign wr_ok  = wr_en && idx_ok(wr_addr);
    assign set_ok = busy_set_en && idx_ok(busy_set_addr);

    // A new producer overrides a same-edge writeback to the same register
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_nxt[busy_set_addr] = 1'b1;
        end
    end

    // Counter tracks the population of busy, moving at most one per edge
    always_comb begin
        cnt_inc = set_ok && !busy[busy_set_addr];
        cnt_dec = wr_ok && busy[wr_addr] &&
                  !(set_ok && (busy_set_addr == wr_addr));
        cnt_nxt = busy_cnt;
        unique case ({cnt_inc, cnt_dec})
            2'b10:   cnt_nxt = busy_cnt + CW'(1);
            2'b01:   cnt_nxt = busy_cnt - CW'(1);
            default: cnt_nxt = busy_cnt;
        endcase
    end

    // Architectural register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Scoreboard state and its population count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        logic            hit;

        assign a   = rd_addr[i*AW +: AW];
        assign hit = (BYPASS != 0) && wr_en && (wr_addr == a);

        // Port read: zero for x0, out-of-range and during reset
        always_comb begin
            d = '0;
            b = 1'b0;
            if (!rst && idx_ok(a)) begin
                d = hit ? wr_data : regs[a];
                b = busy[a] && !hit;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = d;
        assign rd_busy[i]              = b;
    end

    assign stall = |(rd_en & rd_busy);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: one bypassing 32-entry instance and one non-bypassing
// 24-entry instance share stimulus and are checked against hand values.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy_set_en;
    logic [4:0]  busy_set_addr;

    logic [63:0] rd_data1, rd_data0;
    logic [1:0]  rd_busy1, rd_busy0;
    logic        stall1, stall0;
    logic [5:0]  cnt1;
    logic [4:0]  cnt0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)
    ) dut1 (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_busy(rd_busy1), .stall(stall1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .busy_cnt(cnt1)
    );

    regfile_scoreboard #(
        .XLEN(32), .NREGS(24), .NRD(2), .BYPASS(0)
    ) dut0 (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_busy(rd_busy0), .stall(stall0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .busy_cnt(cnt0)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        se;
        logic [4:0]  sa;
        logic [1:0]  re;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  bz;
        logic        st;
        logic [31:0] z0;
        logic [31:0] z1;
        logic [1:0]  zb;
        logic        zs;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic se, input logic [4:0] sa, input logic [1:0] re,
        input logic [4:0] a0, input logic [4:0] a1,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [1:0] bz, input logic st,
        input logic [31:0] z0, input logic [31:0] z1,
        input logic [1:0] zb, input logic zs,
        input logic [5:0] cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.se = se; v.sa = sa; v.re = re;
        v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.bz = bz; v.st = st;
        v.z0 = z0; v.z1 = z1; v.zb = zb; v.zs = zs;
        v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_both(input string tag,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic [1:0] bz, input logic st, input logic [5:0] c1,
        input logic [31:0] z0, input logic [31:0] z1,
        input logic [1:0] zb, input logic zs, input logic [5:0] c0);
        chk({tag, " b1.d0"}, 64'(rd_data1[31:0]), 64'(d0));
        chk({tag, " b1.d1"}, 64'(rd_data1[63:32]), 64'(d1));
        chk({tag, " b1.busy"}, 64'(rd_busy1), 64'(bz));
        chk({tag, " b1.stall"}, 64'(stall1), 64'(st));
        chk({tag, " b1.cnt"}, 64'(cnt1), 64'(c1));
        chk({tag, " b0.d0"}, 64'(rd_data0[31:0]), 64'(z0));
        chk({tag, " b0.d1"}, 64'(rd_data0[63:32]), 64'(z1));
        chk({tag, " b0.busy"}, 64'(rd_busy0), 64'(zb));
        chk({tag, " b0.stall"}, 64'(stall0), 64'(zs));
        chk({tag, " b0.cnt"}, 64'(cnt0), 64'(c0));
    endtask

    task automatic drive(input logic we, input logic [4:0] wa,
        input logic [31:0] wd, input logic se, input logic [4:0] sa,
        input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1);
        wr_en = we; wr_addr = wa; wr_data = wd;
        busy_set_en = se; busy_set_addr = sa;
        rd_en = re; rd_addr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0);

        // we wa wd se sa re a0 a1 | bypass d0 d1 bz st | no-bypass | cnt
        add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd5, 5'd0,
            32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        add(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 2'b00, 5'd1, 5'd2,
            32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b00, 5'd5, 5'd0,
            32'hDEADBEEF, 32'h0, 2'b00, 1'b0,
            32'hDEADBEEF, 32'h0, 2'b00, 1'b0, 6'd0);
        add(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 2'b11, 5'd0, 5'd5,
            32'h0, 32'hDEADBEEF, 2'b00, 1'b0,
            32'h0, 32'hDEADBEEF, 2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd0, 5'd0,
            32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        add(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 2'b11, 5'd7, 5'd7,
            32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0,
            32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd7, 5'd7,
            32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0,
            32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 2'b01, 5'd3, 5'd3,
            32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b01, 5'd3, 5'd3,
            32'h0, 32'h0, 2'b11, 1'b1, 32'h0, 32'h0, 2'b11, 1'b1, 6'd1);
        add(1'b1, 5'd3, 32'h42, 1'b0, 5'd0, 2'b01, 5'd3, 5'd3,
            32'h42, 32'h42, 2'b00, 1'b0, 32'h0, 32'h0, 2'b11, 1'b1, 6'd1);
        add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b01, 5'd3, 5'd3,
            32'h42, 32'h42, 2'b00, 1'b0,
            32'h42, 32'h42, 2'b00, 1'b0, 6'd0);
        add(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 2'b00, 5'd9, 5'd4,
            32'h0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);
        add(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 2'b11, 5'd9, 5'd4,
            32'h99, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 6'd1);
        add(1'b1, 5'd9, 32'h100, 1'b1, 5'd4, 2'b11, 5'd9, 5'd4,
            32'h100, 32'h0, 2'b00, 1'b0,
            32'h99, 32'h0, 2'b01, 1'b1, 6'd1);
        add(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd9, 5'd4,
            32'h100, 32'h0, 2'b10, 1'b1,
            32'h100, 32'h0, 2'b10, 1'b1, 6'd1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.we, v.wa, v.wd, v.se, v.sa, v.re, v.a0, v.a1);
            @(negedge clk);
            chk_both($sformatf("vec%0d", i),
                     v.d0, v.d1, v.bz, v.st, v.cnt,
                     v.z0, v.z1, v.zb, v.zs, v.cnt);
            @(posedge clk);
            #1;
        end

        // x30 exists only in the 32-entry instance
        drive(1'b1, 5'd30, 32'hFFFF, 1'b1, 5'd30, 2'b11, 5'd30, 5'd30);
        @(negedge clk);
        chk_both("oor_same", 32'hFFFF, 32'hFFFF, 2'b00, 1'b0, 6'd1,
                 32'h0, 32'h0, 2'b00, 1'b0, 6'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd30, 5'd30);
        @(negedge clk);
        chk_both("oor_next", 32'hFFFF, 32'hFFFF, 2'b11, 1'b1, 6'd2,
                 32'h0, 32'h0, 2'b00, 1'b0, 6'd1);
        @(posedge clk);
        #1;

        for (int r = 1; r <= 3; r++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 2'b00, 5'd0, 5'd0);
            @(posedge clk);
            #1;
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd1, 5'd5);
        @(negedge clk);
        chk_both("pre_rst", 32'h0, 32'hDEADBEEF, 2'b01, 1'b1, 6'd5,
                 32'h0, 32'hDEADBEEF, 2'b01, 1'b1, 6'd4);

        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_both("in_rst", 32'h0, 32'h0, 2'b00, 1'b0, 6'd0,
                 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 2'b11, 5'd5, 5'd7);
        @(negedge clk);
        chk_both("post_rst", 32'h0, 32'h0, 2'b00, 1'b0, 6'd0,
                 32'h0, 32'h0, 2'b00, 1'b0, 6'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
